pe_tile_grid: RTL and testbench
===============================

PE_TILE_GRID -- requirements
Module: pe_tile_grid

Parameters
REQ-001 SHALL provide ROWS, default 2, PE rows (>=1).
REQ-002 SHALL provide COLS, default 2, PE columns (>=1).
REQ-003 SHALL provide IN_W, default 8, signed width of a operands.
REQ-004 SHALL provide OUT_W, default 19, signed width of b/c/d and weights.
REQ-005 SHALL provide SHIFT_W, default 6, width of control shift.

Interface
REQ-006 SHALL have port clock  in  1  sole clock; all state on rising edge.
REQ-007 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port io_in_a  in  ROWS*IN_W  per-row a; row r in slice r.
REQ-009 SHALL have ports io_in_b and io_in_d  in  COLS*OUT_W  per-column partial sum and preload.
REQ-010 SHALL have ports io_in_control_propagate  in  COLS and io_in_control_shift  in  COLS*SHIFT_W  per-column control.
REQ-011 SHALL have port io_in_valid  in  COLS  per-column valid.
REQ-012 SHALL have port io_clear_sat  in  1  clears all saturation flags.
REQ-013 SHALL have port io_out_a  out  ROWS*IN_W  a leaving the last column.
REQ-014 SHALL have ports io_out_b and io_out_c  out  COLS*OUT_W  from the bottom row.
REQ-015 SHALL have ports io_out_control_propagate  out  COLS, io_out_control_shift  out  COLS*SHIFT_W and io_out_valid  out  COLS  from the bottom row.
REQ-016 SHALL have port io_sat_flag  out  COLS  sticky per-column saturation flag.

Function
REQ-017 SHALL instantiate ROWS x COLS PEs; a flows right along rows; b, d, control and valid flow down columns.
REQ-018 Each PE SHALL register all outputs: one cycle per hop.
- io_out_a row r = io_in_a row r delayed COLS cycles.
- Column outputs = top inputs after ROWS cycles.
REQ-019 Each PE SHALL hold weights c1, c2 (OUT_W signed).
REQ-020 On a valid cycle with propagate=1, a PE SHALL perform all of:
- out_c <= c1 >>> shift;
- out_b <= sat(b + a*c2);
- c1 <= d;
- c2 holds.
REQ-021 On a valid cycle with propagate=0, a PE SHALL perform all of:
- out_c <= c2 >>> shift;
- out_b <= sat(b + a*c1);
- c2 <= d;
- c1 holds.
REQ-022 Shift SHALL be arithmetic; shift >= OUT_W SHALL yield full sign fill.
REQ-023 The MAC SHALL use full precision; sat() SHALL clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-024 On an invalid cycle, a PE SHALL perform all of:
- out_b <= b;
- out_c <= 0;
- c1 and c2 hold;
- no saturation event.
REQ-025 out_a, out_control and out_valid SHALL register their inputs every cycle, regardless of valid.
REQ-026 A saturation event in any PE of column j SHALL set io_sat_flag[j] on the next edge; the flag SHALL remain set until cleared.
REQ-027 io_clear_sat SHALL clear all flags on the next edge; a same-cycle set SHALL take priority (flag=1).

Reset
REQ-028 While reset is high at an edge, all registers SHALL load 0: c1, c2, every pipeline stage, and the flags.
REQ-029 One cycle after reset, every output SHALL read 0.
REQ-030 Reset asserted mid-operation SHALL discard in-flight data; no stale valid SHALL appear after release.

Verification
REQ-031 Reset test: nonzero inputs with reset high for 2 cycles -> all outputs 0 and io_sat_flag=0 on the following cycle.
REQ-032 Preload/compute test (ROWS=COLS=1):
- stimulus: cycle0 valid=1, prop=1, d=5; cycle1 valid=1, prop=0, a=3, b=10;
- response: io_out_b=25 after cycle1; io_out_c=5 after cycle2 with prop=1, shift=0.
REQ-033 Shift test: c1=-20 preloaded, then prop=1 with shift=2 -> io_out_c=-5; shift=40 -> io_out_c=-1.
REQ-034 Saturation test (1x1):
- stimulus: c1=262143, prop=0, a=2, b=0;
- response: io_out_b=262143 and io_sat_flag=1 the next cycle; the flag holds through 3 idle cycles;
- clear: io_clear_sat=1 -> flag 0; clear and saturation in the same cycle -> flag stays 1.
REQ-035 Latency test (2x2): a=7 on row 1 for a single cycle -> io_out_a row 1 =7 exactly 2 cycles later; valid=1 on column 0 -> io_out_valid[0]=1 exactly 2 cycles later.
REQ-036 Invalid/reset-mid test:
- valid=0 with b=9 -> io_out_b=9, io_out_c=0, weights unchanged (checked by a later compute);
- reset mid-stream -> no io_out_valid for ROWS cycles after release.

Source files
------------

// File: rtl/pe_tile_grid.sv
// Systolic PE grid: operand a moves right along the rows; b, preload data, control and valid move down the columns.
// Each PE holds two weights. On every valid cycle it uses one weight in the MAC, outputs the other, and reloads that other one from d.
module pe_tile_grid_pe #(
  parameter int IN_W    = 8,
  parameter int OUT_W   = 19,
  parameter int SHIFT_W = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic signed [IN_W-1:0]    a,
  input  logic signed [OUT_W-1:0]   b,
  input  logic signed [OUT_W-1:0]   d,
  input  logic                      prop,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      valid,
  output logic signed [IN_W-1:0]    a_reg,
  output logic signed [OUT_W-1:0]   b_reg,
  output logic signed [OUT_W-1:0]   c_reg,
  output logic                      prop_reg,
  output logic        [SHIFT_W-1:0] shift_reg,
  output logic                      valid_reg,
  output logic                      sat_hit
);
  localparam int SUM_W = IN_W + OUT_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [OUT_W-1:0] c1, c2, mac_w, out_w, shifted, sum_sat;
  logic signed [SUM_W-1:0] a_x, b_x, w_x, sum;
  int shamt;

  always_comb begin
    mac_w   = prop ? c2 : c1;
    out_w   = prop ? c1 : c2;
    a_x     = {{(SUM_W-IN_W){a[IN_W-1]}}, a};
    b_x     = {{(SUM_W-OUT_W){b[OUT_W-1]}}, b};
    w_x     = {{(SUM_W-OUT_W){mac_w[OUT_W-1]}}, mac_w};
    sum     = b_x + a_x * w_x;
    // A shift of OUT_W-1 or more already gives full sign fill, so larger shifts are clamped to OUT_W-1.
    shamt   = (int'(shift) >= OUT_W) ? OUT_W - 1 : int'(shift);
    shifted = out_w >>> shamt;
    sum_sat = sum[OUT_W-1:0];
    sat_hit = 1'b0;
    if (sum > SAT_MAX) begin
      sum_sat = SAT_MAX[OUT_W-1:0];
      sat_hit = valid;
    end else if (sum < SAT_MIN) begin
      sum_sat = SAT_MIN[OUT_W-1:0];
      sat_hit = valid;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      prop_reg  <= 1'b0;
      shift_reg <= '0;
      valid_reg <= 1'b0;
      c1        <= '0;
      c2        <= '0;
    end else begin
      a_reg     <= a;
      prop_reg  <= prop;
      shift_reg <= shift;
      valid_reg <= valid;
      if (valid) begin
        b_reg <= sum_sat;
        c_reg <= shifted;
        if (prop) c1 <= d;
        else      c2 <= d;
      end else begin
        b_reg <= b;
        c_reg <= '0;
      end
    end
  end
endmodule

module pe_tile_grid #(
  parameter int ROWS    = 2,
  parameter int COLS    = 2,
  parameter int IN_W    = 8,
  parameter int OUT_W   = 19,
  parameter int SHIFT_W = 6
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [ROWS*IN_W-1:0]      io_in_a,
  input  logic [COLS*OUT_W-1:0]     io_in_b,
  input  logic [COLS*OUT_W-1:0]     io_in_d,
  input  logic [COLS-1:0]           io_in_control_propagate,
  input  logic [COLS*SHIFT_W-1:0]   io_in_control_shift,
  input  logic [COLS-1:0]           io_in_valid,
  input  logic                      io_clear_sat,
  output logic [ROWS*IN_W-1:0]      io_out_a,
  output logic [COLS*OUT_W-1:0]     io_out_b,
  output logic [COLS*OUT_W-1:0]     io_out_c,
  output logic [COLS-1:0]           io_out_control_propagate,
  output logic [COLS*SHIFT_W-1:0]   io_out_control_shift,
  output logic [COLS-1:0]           io_out_valid,
  output logic [COLS-1:0]           io_sat_flag
);
  logic [IN_W-1:0]    a_w     [ROWS][COLS+1];
  logic [OUT_W-1:0]   b_w     [ROWS+1][COLS];
  logic [OUT_W-1:0]   d_w     [ROWS+1][COLS];
  logic               prop_w  [ROWS+1][COLS];
  logic [SHIFT_W-1:0] shift_w [ROWS+1][COLS];
  logic               valid_w [ROWS+1][COLS];
  logic               sat_w   [ROWS][COLS];
  logic [COLS-1:0]    sat_col, sat_flag;

  for (genvar r = 0; r < ROWS; r++) begin : g_row_io
    assign a_w[r][0] = io_in_a[r*IN_W +: IN_W];
    assign io_out_a[r*IN_W +: IN_W] = a_w[r][COLS];
  end

  // Each PE's c output feeds the d input of the PE below it, so preloaded weights ripple down the column.
  for (genvar c = 0; c < COLS; c++) begin : g_col_io
    assign b_w[0][c]     = io_in_b[c*OUT_W +: OUT_W];
    assign d_w[0][c]     = io_in_d[c*OUT_W +: OUT_W];
    assign prop_w[0][c]  = io_in_control_propagate[c];
    assign shift_w[0][c] = io_in_control_shift[c*SHIFT_W +: SHIFT_W];
    assign valid_w[0][c] = io_in_valid[c];
    assign io_out_b[c*OUT_W +: OUT_W]                 = b_w[ROWS][c];
    assign io_out_c[c*OUT_W +: OUT_W]                 = d_w[ROWS][c];
    assign io_out_control_propagate[c]                = prop_w[ROWS][c];
    assign io_out_control_shift[c*SHIFT_W +: SHIFT_W] = shift_w[ROWS][c];
    assign io_out_valid[c]                            = valid_w[ROWS][c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_r
    for (genvar c = 0; c < COLS; c++) begin : g_c
      pe_tile_grid_pe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W)) u_pe (
        .clock     (clock),
        .reset     (reset),
        .a         (a_w[r][c]),
        .b         (b_w[r][c]),
        .d         (d_w[r][c]),
        .prop      (prop_w[r][c]),
        .shift     (shift_w[r][c]),
        .valid     (valid_w[r][c]),
        .a_reg     (a_w[r][c+1]),
        .b_reg     (b_w[r+1][c]),
        .c_reg     (d_w[r+1][c]),
        .prop_reg  (prop_w[r+1][c]),
        .shift_reg (shift_w[r+1][c]),
        .valid_reg (valid_w[r+1][c]),
        .sat_hit   (sat_w[r][c])
      );
    end
  end

  always_comb begin
    sat_col = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        sat_col[c] = sat_col[c] | sat_w[r][c];
  end

  // When a saturation event and a clear arrive in the same cycle, the event wins.
  always_ff @(posedge clock) begin
    if (reset) sat_flag <= '0;
    else       sat_flag <= sat_col | (sat_flag & {COLS{~io_clear_sat}});
  end

  assign io_sat_flag = sat_flag;
endmodule

// File: tb/tb_pe_tile_grid.sv
// Bench for pe_tile_grid: a 1x1 grid checked cycle-by-cycle against an arithmetic model, and a 2x2 grid checked against delay lines.
// Directed vectors with literal expected values cover reset, preload/compute, shift, saturation, latency and mid-stream reset.
module tb_pe_tile_grid;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  a1;     logic [18:0] b1, d1;  logic [0:0] prop1, valid1; logic [5:0]  shift1; logic clr1;
  logic [7:0]  oa1;    logic [18:0] ob1, oc1; logic [0:0] op1, ov1, sat1; logic [5:0]  os1;
  logic [15:0] a2;     logic [37:0] b2, d2;  logic [1:0] prop2, valid2; logic [11:0] shift2; logic clr2;
  logic [15:0] oa2;    logic [37:0] ob2, oc2; logic [1:0] op2, ov2, sat2; logic [11:0] os2;

  pe_tile_grid #(.ROWS(1), .COLS(1)) dut1 (
    .clock(clk), .reset(rst), .io_in_a(a1), .io_in_b(b1), .io_in_d(d1),
    .io_in_control_propagate(prop1), .io_in_control_shift(shift1), .io_in_valid(valid1),
    .io_clear_sat(clr1), .io_out_a(oa1), .io_out_b(ob1), .io_out_c(oc1),
    .io_out_control_propagate(op1), .io_out_control_shift(os1), .io_out_valid(ov1),
    .io_sat_flag(sat1));

  pe_tile_grid #(.ROWS(2), .COLS(2)) dut2 (
    .clock(clk), .reset(rst), .io_in_a(a2), .io_in_b(b2), .io_in_d(d2),
    .io_in_control_propagate(prop2), .io_in_control_shift(shift2), .io_in_valid(valid2),
    .io_clear_sat(clr2), .io_out_a(oa2), .io_out_b(ob2), .io_out_c(oc2),
    .io_out_control_propagate(op2), .io_out_control_shift(os2), .io_out_valid(ov2),
    .io_sat_flag(sat2));

  int n_total = 0;
  int n_pass  = 0;
  int edges   = 0;

  function automatic void chk(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  localparam longint MAXV = 262143;
  localparam longint MINV = -262144;

  function automatic longint ashr(longint v, int s);
    if (s >= 19) return (v < 0) ? -1 : 0;
    return v >>> s;
  endfunction

  // 1x1 model: two weights plus the registered outputs.
  longint m_c1, m_c2, m_b, m_c, m_a;
  longint m_valid, m_prop, m_shift, m_flag;
  // 2x2 model: two-deep delay lines for the pure pipeline signals.
  logic [15:0] h_a [2];
  logic [1:0]  h_v [2], h_p [2];
  logic [11:0] h_s [2];

  always @(posedge clk) begin : model
    longint a, b, d, full;
    bit ev;
    edges++;
    if (rst) begin
      m_c1 = 0; m_c2 = 0; m_b = 0; m_c = 0; m_a = 0;
      m_valid = 0; m_prop = 0; m_shift = 0; m_flag = 0;
      for (int i = 0; i < 2; i++) begin h_a[i] = '0; h_v[i] = '0; h_p[i] = '0; h_s[i] = '0; end
    end else begin
      a  = longint'($signed(a1));
      b  = longint'($signed(b1));
      d  = longint'($signed(d1));
      ev = 1'b0;
      if (valid1[0]) begin
        if (prop1[0]) begin m_c = ashr(m_c1, int'(shift1)); full = b + a * m_c2; m_c1 = d; end
        else          begin m_c = ashr(m_c2, int'(shift1)); full = b + a * m_c1; m_c2 = d; end
        if (full > MAXV)      begin m_b = MAXV; ev = 1'b1; end
        else if (full < MINV) begin m_b = MINV; ev = 1'b1; end
        else                  m_b = full;
      end else begin
        m_b = b;
        m_c = 0;
      end
      if (ev)        m_flag = 1;
      else if (clr1) m_flag = 0;
      m_a = a; m_valid = longint'(valid1); m_prop = longint'(prop1); m_shift = longint'(shift1);
      h_a[1] = h_a[0]; h_a[0] = a2;
      h_v[1] = h_v[0]; h_v[0] = valid2;
      h_p[1] = h_p[0]; h_p[0] = prop2;
      h_s[1] = h_s[0]; h_s[0] = shift2;
    end
  end

  always @(posedge clk) begin : compare
    #2;
    if (edges > 0) begin
      chk("m_b1",   longint'($signed(ob1)), m_b);
      chk("m_c1",   longint'($signed(oc1)), m_c);
      chk("m_a1",   longint'($signed(oa1)), m_a);
      chk("m_v1",   longint'(ov1), m_valid);
      chk("m_p1",   longint'(op1), m_prop);
      chk("m_s1",   longint'(os1), m_shift);
      chk("m_sat1", longint'(sat1), m_flag);
      chk("m_a2",   longint'(oa2), longint'(h_a[1]));
      chk("m_v2",   longint'(ov2), longint'(h_v[1]));
      chk("m_p2",   longint'(op2), longint'(h_p[1]));
      chk("m_s2",   longint'(os2), longint'(h_s[1]));
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic idle();
    a1 = '0; b1 = '0; d1 = '0; prop1 = '0; shift1 = '0; valid1 = '0; clr1 = 1'b0;
    a2 = '0; b2 = '0; d2 = '0; prop2 = '0; shift2 = '0; valid2 = '0; clr2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a1 = 8'h5a; b1 = 19'd77; d1 = 19'd33; prop1 = 1'b1; shift1 = 6'd3; valid1 = 1'b1; clr1 = 1'b1;
    a2 = 16'h1234; b2 = 38'h12345; d2 = 38'h777; prop2 = 2'b11; shift2 = 12'h0c3; valid2 = 2'b11; clr2 = 1'b0;
    step(); step();
    chk("rst_b1",   longint'(ob1), 0);
    chk("rst_c1",   longint'(oc1), 0);
    chk("rst_a1",   longint'(oa1), 0);
    chk("rst_sat1", longint'(sat1), 0);
    chk("rst_v2",   longint'(ov2), 0);
    chk("rst_b2",   longint'(ob2), 0);
    rst = 1'b0;
    idle();

    // Preload c1=5, then compute with it, then read it back.
    valid1 = 1'b1; prop1 = 1'b1; d1 = 19'd5; step();
    prop1 = 1'b0; a1 = 8'd3; b1 = 19'd10; d1 = '0; step();
    chk("pre_b", longint'($signed(ob1)), 25);
    prop1 = 1'b1; a1 = '0; b1 = '0; shift1 = '0; step();
    chk("pre_c", longint'($signed(oc1)), 5);

    // Arithmetic shift of a negative weight, including an oversized shift.
    d1 = 19'(-20); step();
    shift1 = 6'd2; step();
    chk("shr2", longint'($signed(oc1)), -5);
    shift1 = 6'd40; step();
    chk("shr40", longint'($signed(oc1)), -1);

    // Positive saturation and sticky flag behaviour.
    shift1 = '0; d1 = 19'd262143; step();
    prop1 = 1'b0; a1 = 8'd2; d1 = '0; step();
    chk("sat_b", longint'($signed(ob1)), 262143);
    chk("sat_f", longint'(sat1), 1);
    valid1 = 1'b0; a1 = '0; prop1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_hold", longint'(sat1), 1);
    end
    clr1 = 1'b1; step();
    chk("sat_clr", longint'(sat1), 0);
    valid1 = 1'b1; a1 = 8'd2; step();
    chk("sat_prio", longint'(sat1), 1);
    valid1 = 1'b0; a1 = '0; step();
    chk("sat_clr2", longint'(sat1), 0);
    clr1 = 1'b0;

    // Negative saturation.
    valid1 = 1'b1; prop1 = 1'b0; a1 = 8'(-128); b1 = 19'(-5); step();
    chk("sat_neg", longint'($signed(ob1)), -262144);
    chk("sat_negf", longint'(sat1), 1);

    // Invalid cycle passes b, zeroes c and leaves weights alone.
    a1 = '0; b1 = '0; d1 = 19'd7; step();
    valid1 = 1'b0; b1 = 19'd9; d1 = 19'd123; prop1 = 1'b1; step();
    chk("inv_b", longint'($signed(ob1)), 9);
    chk("inv_c", longint'($signed(oc1)), 0);
    valid1 = 1'b1; prop1 = 1'b1; a1 = 8'd1; b1 = '0; d1 = '0; shift1 = '0; step();
    chk("inv_w2", longint'($signed(ob1)), 7);
    chk("inv_w1", longint'($signed(oc1)), 262143);

    // 2x2 latency: row-1 a, column-0 valid, column-1 b through invalid PEs.
    idle();
    a2 = 16'h0700; valid2 = 2'b01; b2 = {19'd100, 19'd0}; step();
    idle();
    chk("lat1_a", longint'(oa2[15:8]), 0);
    chk("lat1_v", longint'(ov2[0]), 0);
    step();
    chk("lat2_a", longint'(oa2[15:8]), 7);
    chk("lat2_v", longint'(ov2[0]), 1);
    chk("lat2_b", longint'(ob2[37:19]), 100);
    chk("lat2_c", longint'(oc2), 0);
    step();
    chk("lat3_a", longint'(oa2[15:8]), 0);
    chk("lat3_v", longint'(ov2[0]), 0);

    // Reset in the middle of a valid stream.
    valid1 = 1'b1; valid2 = 2'b11; step(); step();
    rst = 1'b1; step();
    rst = 1'b0; valid1 = 1'b0; valid2 = 2'b00;
    chk("rmid_v2", longint'(ov2), 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rmid_post_v2", longint'(ov2), 0);
      chk("rmid_post_v1", longint'(ov1), 0);
    end
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
